// File: rtl/term_sequencer.sv
// Sequencer for the term-project datapath: stores DEPTH bytes, launches compute, then loads the BCD display.
// Optional compute-wait watchdog enabled by defining SEQ_CALC_TIMEOUT_EN.
module term_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          calc_start,
  input  logic          calc_done,
  output logic          bcd_load,
  output logic [1:0]    phase,
  output logic          busy,
  output logic          err
);

  if (DEPTH < 2 || DEPTH > 256 || (1 << AW) != DEPTH || TIMEOUT < 1) begin : g_param_check
    $error("term_sequencer: inconsistent DEPTH/AW/TIMEOUT");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STORE   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DISPLAY = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          init_q;
  logic          init_rise;
  logic [AW-1:0] ptr, ptr_n;
  logic          full, full_n;
  logic          we_n, start_n, load_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;

`ifdef SEQ_CALC_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr, tmr_n;
  logic          err_q, err_n;
`endif

  assign init_rise = init & ~init_q;
  assign phase     = state;
  // full marks the cycle the last write is on the bus; no more bytes are taken then
  assign data_ready = (state == S_STORE) && !full;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    full_n  = full;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    start_n = 1'b0;
    load_n  = 1'b0;
`ifdef SEQ_CALC_TIMEOUT_EN
    tmr_n   = tmr;
    err_n   = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (init_rise) begin
          state_n = S_STORE;
          ptr_n   = '0;
          full_n  = 1'b0;
`ifdef SEQ_CALC_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      S_STORE: begin
        if (init_rise) begin
          state_n = S_IDLE;
        end else if (full) begin
          state_n = S_COMPUTE;
          start_n = 1'b1;
`ifdef SEQ_CALC_TIMEOUT_EN
          tmr_n   = '0;
`endif
        end else if (data_valid) begin
          we_n    = 1'b1;
          addr_n  = ptr;
          wdata_n = data_in;
          if (ptr == AW'(DEPTH - 1)) full_n = 1'b1;
          else                       ptr_n  = ptr + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (init_rise) begin
          state_n = S_IDLE;
        end else if (!calc_start) begin
          if (calc_done) begin
            state_n = S_DISPLAY;
            load_n  = 1'b1;
          end
`ifdef SEQ_CALC_TIMEOUT_EN
          else if (tmr == TW'(TIMEOUT - 1)) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end else begin
            tmr_n = tmr + 1'b1;
          end
`endif
        end
      end
      S_DISPLAY: begin
        if (init_rise) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      init_q     <= 1'b0;
      ptr        <= '0;
      full       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      calc_start <= 1'b0;
      bcd_load   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      init_q     <= init;
      ptr        <= ptr_n;
      full       <= full_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      calc_start <= start_n;
      bcd_load   <= load_n;
      busy       <= (state_n == S_STORE) || (state_n == S_COMPUTE);
    end
  end

`ifdef SEQ_CALC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      tmr   <= tmr_n;
      err_q <= err_n;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
